// File: rtl/cpu_control_unit_pkg.sv
// rtl/cpu_control_unit_pkg.sv - shared state codes and opcodes for the control sequencer
// Package cpu_ctrl_defs: state encodings (state_dbg values) and the opcode
// constants that are also used by the instruction decoder's regwe logic.
package cpu_ctrl_defs;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_FETCH   = 4'd1;
    localparam logic [3:0] ST_DECODE  = 4'd2;
    localparam logic [3:0] ST_REGREAD = 4'd3;
    localparam logic [3:0] ST_EXEC    = 4'd4;
    localparam logic [3:0] ST_MEM     = 4'd5;
    localparam logic [3:0] ST_WB      = 4'd6;
    localparam logic [3:0] ST_HALT    = 4'd7;
    localparam logic [3:0] ST_FAULT   = 4'd8;

    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1101;
    localparam logic [3:0] OP_BR  = 4'b1100;
    localparam logic [3:0] OP_CMP = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/cpu_control_unit_mem_wait_timer.sv
// rtl/cpu_control_unit_mem_wait_timer.sv - memory wait-cycle counter with timeout expiry
// Ports: clk, rst_n (async active-low), clear_i (zero the count),
// count_i (one more unacknowledged request cycle), expire_o (this cycle
// is the last permitted unacknowledged one).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (count_i) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Expiry is only meaningful while a request is still waiting; an ack in
    // the same cycle suppresses count_i and therefore wins over the timeout.
    assign expire_o = count_i && (timer_q == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle sequencer for the 16-bit RISC core
// Inputs:  clk, rst_n, run, instr_op[3:0], branch_taken, mem_ack.
// Outputs: mem_req/mem_we/mem_addr_sel (memory port), en_fetch/pc_inc/pc_load
// (IR and PC), en_decode/en_regread/en_alu/en_regwrite/wb_sel (datapath),
// halted, fault, state_dbg[3:0], instr_count[CNT_W-1:0].
module cpu_control_unit
    import cpu_ctrl_defs::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       instr_op,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             en_fetch,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             en_decode,
    output logic             en_regread,
    output logic             en_alu,
    output logic             en_regwrite,
    output logic             wb_sel,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             cnt_inc;
    logic             in_req;
    logic             tmr_count;
    logic             tmr_clear;
    logic             tmr_expire;

    assign in_req    = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_count = in_req && !mem_ack;
    // Clearing on any state change means every FETCH/MEM visit starts at zero.
    assign tmr_clear = !tmr_count || (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tmr_clear),
        .count_i (tmr_count),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack)         state_d = ST_DECODE;
                else if (tmr_expire) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                op_d    = instr_op;
                state_d = ST_REGREAD;
            end
            ST_REGREAD: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LD, OP_ST:  state_d = ST_MEM;
                    OP_BR, OP_CMP: retire  = 1'b1;
                    OP_HLT: begin
                        state_d = ST_HALT;
                        cnt_inc = 1'b1;
                    end
                    default:       state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_LD) state_d = ST_WB;
                    else               retire  = 1'b1;
                end else if (tmr_expire) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                retire = 1'b1;
            end
            ST_HALT, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retirement is a transition, not a state: count and pick the next
        // instruction (or idle) in the same edge that leaves EXEC/MEM/WB.
        if (retire) begin
            cnt_inc = 1'b1;
            state_d = run ? ST_FETCH : ST_IDLE;
        end
    end

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, cnt_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode from the registered state; en_fetch/pc_inc and pc_load also
    // look at this cycle's mem_ack / branch_taken.
    assign mem_req      = in_req;
    assign mem_addr_sel = (state_q == ST_MEM);
    assign mem_we       = (state_q == ST_MEM) && (op_q == OP_ST);
    assign en_fetch     = (state_q == ST_FETCH) && mem_ack;
    assign pc_inc       = (state_q == ST_FETCH) && mem_ack;
    assign en_decode    = (state_q == ST_DECODE);
    assign en_regread   = (state_q == ST_REGREAD);
    assign en_alu       = (state_q == ST_EXEC);
    assign pc_load      = (state_q == ST_EXEC) && (op_q == OP_BR) && branch_taken;
    assign en_regwrite  = (state_q == ST_WB);
    assign wb_sel       = (state_q == ST_WB) && (op_q == OP_LD);
    assign halted       = (state_q == ST_HALT);
    assign fault        = (state_q == ST_FAULT);
    assign state_dbg    = state_q;
    assign instr_count  = cnt_q;

endmodule
